// File: rtl/tree_sum_accumulator.sv
// tree_sum_accumulator
// Accumulates a stream of adder-tree root sums into groups of k_len beats and
// presents one ACC_W-bit result per group with a sticky overflow flag.
// Optional build macro: TREE_ACC_SATURATE_EN -- when defined the accumulator
// clamps to the representable limit on overflow instead of wrapping.

module tree_sum_accumulator #(
  parameter int P     = 9,
  parameter int ACC_W = 32,
  parameter int KW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [P-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signedAddition,
  input  logic [KW-1:0]    k_len,
  output logic [ACC_W-1:0] out_data,
  output logic             out_overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           r_state;
  logic [KW-1:0]    r_count;
  logic [KW-1:0]    r_k;
  logic             r_sign;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W-1:0] r_outData;
  logic             r_outOvf;
  logic             r_outValid;

  logic             w_inReady;
  logic             w_accept;
  logic             w_firstBeat;
  logic             w_beatSign;
  logic             w_lastBeat;
  logic             w_addOvf;
  logic [KW-1:0]    w_kEff;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_next;
  logic [ACC_W:0]   w_sumFull;

  // A held result blocks new input unless the consumer takes it this cycle,
  // which is what allows a new group to start with no bubble.
  assign w_inReady   = rst_n && ((r_state != HOLD) || out_ready);
  assign w_accept    = in_valid && w_inReady;

  // Any beat accepted outside ACCUM opens a new group.
  assign w_firstBeat = (r_state != ACCUM);
  assign w_kEff      = (k_len == '0) ? KW'(1) : k_len;
  assign w_beatSign  = w_firstBeat ? signedAddition : r_sign;

  assign w_ext = w_beatSign ? {{(ACC_W-P){in_data[P-1]}}, in_data}
                            : {{(ACC_W-P){1'b0}}, in_data};

  assign w_sumFull = {1'b0, r_acc} + {1'b0, w_ext};
  assign w_sum     = w_sumFull[ACC_W-1:0];

  // Signed mode: operands agree in sign but the sum does not. Unsigned: carry out.
  assign w_addOvf = r_sign ? ((r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                              (w_sum[ACC_W-1] != r_acc[ACC_W-1]))
                           : w_sumFull[ACC_W];

  assign w_lastBeat = ((r_count + KW'(1)) == r_k);

`ifdef TREE_ACC_SATURATE_EN
  logic             r_sat;
  logic [ACC_W-1:0] w_clamp;

  // In signed mode the direction of overflow follows the accumulator sign,
  // since overflow only happens when both operands share that sign.
  assign w_clamp = r_sign ? (r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                            : {1'b0, {(ACC_W-1){1'b1}}})
                          : {ACC_W{1'b1}};
  assign w_next  = r_sat ? r_acc : (w_addOvf ? w_clamp : w_sum);

  // Once clamped, the accumulator stays pinned for the rest of the group.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (w_accept && w_firstBeat) begin
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_sat <= r_sat | w_addOvf;
    end
  end
`else
  assign w_next = w_sum;
`endif

  // Group FSM: opens groups, accumulates beats, and holds the result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_k        <= '0;
      r_sign     <= 1'b0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_outData  <= '0;
      r_outOvf   <= 1'b0;
      r_outValid <= 1'b0;
    end else if (w_accept && w_firstBeat) begin
      r_k     <= w_kEff;
      r_sign  <= signedAddition;
      r_acc   <= w_ext;
      r_ovf   <= 1'b0;
      r_count <= KW'(1);
      if (w_kEff == KW'(1)) begin
        r_state    <= HOLD;
        r_outData  <= w_ext;
        r_outOvf   <= 1'b0;
        r_outValid <= 1'b1;
      end else begin
        r_state    <= ACCUM;
        r_outValid <= 1'b0;
      end
    end else if (w_accept) begin
      r_acc   <= w_next;
      r_ovf   <= r_ovf | w_addOvf;
      r_count <= r_count + KW'(1);
      if (w_lastBeat) begin
        r_state    <= HOLD;
        r_outData  <= w_next;
        r_outOvf   <= r_ovf | w_addOvf;
        r_outValid <= 1'b1;
      end
    end else if ((r_state == HOLD) && out_ready) begin
      r_state    <= IDLE;
      r_outValid <= 1'b0;
    end
  end

  assign in_ready     = w_inReady;
  assign out_data     = r_outData;
  assign out_overflow = r_outOvf;
  assign out_valid    = r_outValid;

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// tb_tree_sum_accumulator
// Drives two accumulators (ACC_W=32 and ACC_W=10) from one stimulus stream.
// A group-level reference model queues expected results; a monitor pops and
// compares them whenever a result is presented.

module tb_tree_sum_accumulator;

  localparam int P  = 9;
  localparam int KW = 16;
`ifdef TREE_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [P-1:0]  in_data;
  logic          in_valid;
  logic          signedAddition;
  logic [KW-1:0] k_len;
  logic          out_ready;

  logic          inReadyA, inReadyB;
  logic [31:0]   outDataA;
  logic [9:0]    outDataB;
  logic          ovfA, ovfB, validA, validB;

  typedef struct {
    logic [31:0] dataA;
    logic        ovfA;
    logic [9:0]  dataB;
    logic        ovfB;
  } result_t;

  result_t expQ[$];
  int      nChecks = 0;
  int      nFails  = 0;

  // model state for the group currently being collected
  bit      holding = 1'b0;
  bit      inGroup = 1'b0;
  int      beatCount, kTarget;
  bit      grpSign;
  longint  accA, accB, beatVal;
  bit      mOvfA, mOvfB, mSatA, mSatB;
  bit      expReady;
  result_t res;

  always #5 clk = ~clk;

  tree_sum_accumulator #(.P(P), .ACC_W(32), .KW(KW)) dutA (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(inReadyA), .signedAddition(signedAddition), .k_len(k_len),
    .out_data(outDataA), .out_overflow(ovfA), .out_valid(validA),
    .out_ready(out_ready)
  );

  tree_sum_accumulator #(.P(P), .ACC_W(10), .KW(KW)) dutB (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(inReadyB), .signedAddition(signedAddition), .k_len(k_len),
    .out_data(outDataB), .out_overflow(ovfB), .out_valid(validB),
    .out_ready(out_ready)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One addition on a W-bit accumulator, done with plain integer arithmetic
  // and range checks rather than bit-level carry logic.
  task automatic modelStep(input int w, input bit sgn, inout longint acc,
                           inout bit ovf, inout bit sat, input longint b);
    longint nx, lo, hi, m;
    m = longint'(1) <<< w;
    if (sgn) begin
      lo = -(m >>> 1);
      hi = (m >>> 1) - 1;
    end else begin
      lo = 0;
      hi = m - 1;
    end
    if (sat) return;
    nx = acc + b;
    if (nx < lo || nx > hi) begin
      ovf = 1'b1;
      if (SAT) begin
        sat = 1'b1;
        acc = (nx > hi) ? hi : lo;
      end else begin
        acc = nx & (m - 1);
        if (sgn && acc > hi) acc = acc - m;
      end
    end else begin
      acc = nx;
    end
  endtask

  // Reference model: tracks handshakes at the group level and queues results.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("inReadyInResetA", inReadyA, 0);
      checkOutput("inReadyInResetB", inReadyB, 0);
      holding = 1'b0;
      inGroup = 1'b0;
      expQ.delete();
    end else begin
      expReady = !holding || out_ready;
      checkOutput("inReadyA", inReadyA, expReady);
      checkOutput("inReadyB", inReadyB, expReady);
      checkOutput("outValidA", validA, holding);
      checkOutput("outValidB", validB, holding);
      if (holding && out_ready) holding = 1'b0;
      if (in_valid && expReady) begin
        if (!inGroup) begin
          kTarget   = (k_len == 0) ? 1 : int'(k_len);
          grpSign   = signedAddition;
          beatVal   = grpSign ? longint'($signed(in_data)) : longint'(in_data);
          accA      = beatVal;
          accB      = beatVal;
          mOvfA     = 1'b0;
          mOvfB     = 1'b0;
          mSatA     = 1'b0;
          mSatB     = 1'b0;
          beatCount = 1;
          inGroup   = 1'b1;
        end else begin
          beatVal = grpSign ? longint'($signed(in_data)) : longint'(in_data);
          modelStep(32, grpSign, accA, mOvfA, mSatA, beatVal);
          modelStep(10, grpSign, accB, mOvfB, mSatB, beatVal);
          beatCount++;
        end
        if (beatCount == kTarget) begin
          res.dataA = accA[31:0];
          res.ovfA  = mOvfA;
          res.dataB = accB[9:0];
          res.ovfB  = mOvfB;
          expQ.push_back(res);
          inGroup = 1'b0;
          holding = 1'b1;
        end
      end
    end
  end

  // Monitor: every presented result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && validA) begin
      if (expQ.size() == 0) begin
        checkOutput("resultWithNoneExpected", 64'(expQ.size()), 1);
      end else begin
        checkOutput("outDataA", outDataA, expQ[0].dataA);
        checkOutput("outOverflowA", ovfA, expQ[0].ovfA);
        checkOutput("outDataB", outDataB, expQ[0].dataB);
        checkOutput("outOverflowB", ovfB, expQ[0].ovfB);
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input bit v, input logic [P-1:0] d, input bit s,
                               input int k, input bit r, input bit rstN);
    @(posedge clk);
    #1;
    in_valid       = v;
    in_data        = d;
    signedAddition = s;
    k_len          = KW'(k);
    out_ready      = r;
    rst_n          = rstN;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; signedAddition = 1'b0;
    k_len = '0; out_ready = 1'b1;
    repeat (3) applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 1);
    @(negedge clk);
    checkOutput("resetDataA", outDataA, 0);
    checkOutput("resetDataB", outDataB, 0);
    checkOutput("resetOvfA", ovfA, 0);

    // unsigned group of four, result one cycle after the last beat
    applyStimulus(1, 9'd10, 0, 4, 1, 1);
    applyStimulus(1, 9'd20, 0, 4, 1, 1);
    applyStimulus(1, 9'd30, 0, 4, 1, 1);
    applyStimulus(1, 9'd40, 0, 4, 1, 1);
    applyStimulus(0, 0, 0, 4, 1, 1);
    @(negedge clk);
    checkOutput("sum100Valid", validA, 1);
    checkOutput("sum100Data", outDataA, 100);
    checkOutput("sum100Ovf", ovfA, 0);

    // signed -1 + -2 + 3
    applyStimulus(1, 9'h1FF, 1, 3, 1, 1);
    applyStimulus(1, 9'h1FE, 1, 3, 1, 1);
    applyStimulus(1, 9'h003, 1, 3, 1, 1);
    applyStimulus(0, 0, 0, 3, 1, 1);
    @(negedge clk);
    checkOutput("signedZeroData", outDataA, 0);

    // single-beat groups with k_len 0 and 1
    applyStimulus(1, 9'd7, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(1, 9'd7, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 1, 1, 1);

    // consumer stalls for several cycles, then takes the result while a new group starts
    applyStimulus(1, 9'd100, 0, 2, 0, 1);
    applyStimulus(1, 9'd23, 0, 2, 0, 1);
    repeat (6) applyStimulus(1, 9'd5, 0, 2, 0, 1);
    applyStimulus(1, 9'd5, 0, 2, 1, 1);
    applyStimulus(1, 9'd6, 0, 2, 1, 1);
    applyStimulus(0, 0, 0, 2, 1, 1);
    applyStimulus(0, 0, 0, 2, 1, 1);

    // unsigned overflow on the narrow accumulator
    applyStimulus(1, 9'd511, 0, 3, 1, 1);
    applyStimulus(1, 9'd511, 0, 3, 1, 1);
    applyStimulus(1, 9'd511, 0, 3, 1, 1);
    applyStimulus(0, 0, 0, 3, 1, 1);
    @(negedge clk);
    checkOutput("ovfNarrowFlag", ovfB, 1);
    checkOutput("ovfNarrowData", outDataB, SAT ? 1023 : 509);
    checkOutput("ovfWideData", outDataA, 1533);

    // reset in the middle of a group discards it
    applyStimulus(1, 9'd50, 0, 4, 1, 1);
    applyStimulus(1, 9'd60, 0, 4, 1, 1);
    applyStimulus(0, 0, 0, 4, 1, 0);
    applyStimulus(1, 9'd1, 0, 4, 1, 1);
    applyStimulus(1, 9'd2, 0, 4, 1, 1);
    applyStimulus(1, 9'd3, 0, 4, 1, 1);
    applyStimulus(1, 9'd4, 0, 4, 1, 1);
    applyStimulus(0, 0, 0, 4, 1, 1);
    @(negedge clk);
    checkOutput("postResetSum", outDataA, 10);

    // random traffic: sign and length change freely, including mid-group
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 9'($urandom), 1'($urandom),
                    $urandom_range(0, 5), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 299) != 0);
    end

    repeat (12) applyStimulus(0, 0, 0, 1, 1, 1);
    @(negedge clk);
    checkOutput("queueDrained", 64'(expQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
